// File: rtl/conv_addr_unit.sv
// Address and loop-counter unit for the convolution engine: SRAM/weight-memory
// address generation, header capture, sentinel detection and output-edge flags.
module conv_addr_unit (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        dut_busy_toggle,
   input  logic        incr_raddr_enable,
   input  logic        incr_waddr_enable,
   input  logic        rst_dut_wmem_read_address,
   input  logic        str_weights_dims,
   input  logic        str_input_nrows,
   input  logic        str_input_ncols,
   input  logic        incr_col_enable,
   input  logic        incr_row_enable,
   input  logic        rst_col_counter,
   input  logic        rst_row_counter,
   input  logic [15:0] sram_dut_read_data,
   output logic [11:0] dut_sram_read_address,
   output logic [11:0] dut_sram_write_address,
   output logic [11:0] dut_wmem_read_address,
   output logic        dut_busy,
   output logic        end_condition_met,
   output logic        last_col_next,
   output logic        last_row_flag
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [15:0] SENTINEL = 16'h00FF;

   logic [0:0]  state_reg, state_next;
   logic [11:0] raddr_reg, raddr_next;
   logic [11:0] waddr_reg, waddr_next;
   logic [11:0] wmem_reg, wmem_next;
   logic        end_reg, end_next;
   logic        sentinel_seen;
   logic        start_run;

   // Index 0 is the column loop, index 1 the row loop.
   logic [7:0]  cnt_reg  [2];
   logic [7:0]  cnt_next [2];
   logic [7:0]  dim_reg  [2];
   logic [7:0]  dim_next [2];
   logic        cnt_clr  [2];
   logic        cnt_inc  [2];
   logic        dim_str  [2];
   logic        last_flag[2];

   assign sentinel_seen = str_input_nrows && (sram_dut_read_data == SENTINEL);
   assign start_run     = (state_reg == IDLE) && dut_busy_toggle;

   assign cnt_clr[0] = rst_col_counter;
   assign cnt_clr[1] = rst_row_counter;
   assign cnt_inc[0] = incr_col_enable;
   assign cnt_inc[1] = incr_row_enable;
   assign dim_str[0] = str_input_ncols;
   assign dim_str[1] = str_input_nrows && !sentinel_seen;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (dut_busy_toggle) state_next = BUSY;
         BUSY:    if (sentinel_seen)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      raddr_next = raddr_reg;
      if (incr_raddr_enable) raddr_next = raddr_reg + 12'd1;

      waddr_next = waddr_reg;
      if (start_run)              waddr_next = 12'h000;
      else if (incr_waddr_enable) waddr_next = waddr_reg + 12'd1;

      // Address 0 holds the dimensions; the weight word follows at address 1.
      wmem_next = wmem_reg;
      if (rst_dut_wmem_read_address) wmem_next = 12'h000;
      else if (str_weights_dims)     wmem_next = 12'h001;

      end_next = end_reg;
      if (sentinel_seen)  end_next = 1'b1;
      else if (start_run) end_next = 1'b0;
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_loop
         always_comb begin
            cnt_next[gi] = cnt_reg[gi];
            if (cnt_clr[gi])
               cnt_next[gi] = 8'h00;
            else if (cnt_inc[gi] && (cnt_reg[gi] != 8'hFF))
               cnt_next[gi] = cnt_reg[gi] + 8'd1;

            dim_next[gi] = dim_reg[gi];
            if (dim_str[gi]) dim_next[gi] = sram_dut_read_data[7:0];
         end

         // Widened to 9 bits so dim-3 cannot underflow for small dimensions.
         assign last_flag[gi] = ({1'b0, dim_reg[gi]} < 9'd3) ||
                                ({1'b0, cnt_reg[gi]} >= ({1'b0, dim_reg[gi]} - 9'd3));

         always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
               cnt_reg[gi] <= 8'h00;
               dim_reg[gi] <= 8'h00;
            end else begin
               cnt_reg[gi] <= cnt_next[gi];
               dim_reg[gi] <= dim_next[gi];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_reg <= IDLE;
         raddr_reg <= 12'h000;
         waddr_reg <= 12'h000;
         wmem_reg  <= 12'h000;
         end_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         raddr_reg <= raddr_next;
         waddr_reg <= waddr_next;
         wmem_reg  <= wmem_next;
         end_reg   <= end_next;
      end
   end

   assign dut_sram_read_address  = raddr_reg;
   assign dut_sram_write_address = waddr_reg;
   assign dut_wmem_read_address  = wmem_reg;
   assign dut_busy               = (state_reg == BUSY);
   assign end_condition_met      = end_reg;
   assign last_col_next          = last_flag[0];
   assign last_row_flag          = last_flag[1];

endmodule

// File: doc/conv_addr_unit.md
CONV_ADDR_UNIT -- requirements
Module: conv_addr_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; reset_b  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have strobe inputs, each 1 bit, one-cycle pulses from the convolution controller:
- dut_busy_toggle
- incr_raddr_enable
- incr_waddr_enable
- rst_dut_wmem_read_address
- str_weights_dims
- str_input_nrows
- str_input_ncols
- incr_col_enable
- incr_row_enable
- rst_col_counter
- rst_row_counter
REQ-003 SHALL have sram_dut_read_data  in  16  input SRAM read data, valid one cycle after the address is presented.
REQ-004 SHALL have outputs:
- dut_sram_read_address  out  12  input SRAM read address.
- dut_sram_write_address  out  12  output SRAM write address.
- dut_wmem_read_address  out  12  weight memory read address.
REQ-005 SHALL have outputs:
- dut_busy  out  1  run in progress.
- end_condition_met  out  1  sentinel seen.
- last_col_next  out  1  final output column.
- last_row_flag  out  1  final output row.

Function
REQ-006 SHALL implement a 2-state FSM, IDLE and BUSY. In IDLE, dut_busy_toggle moves to BUSY. In BUSY, a capture of the 16'h00FF sentinel by str_input_nrows moves to IDLE on the next edge.
REQ-007 SHALL drive dut_busy=1 exactly while the FSM is in BUSY.
REQ-008 SHALL treat dut_busy_toggle in BUSY as having no effect.
REQ-009 SHALL, on dut_busy_toggle in IDLE, clear dut_sram_write_address and end_condition_met on the same edge.
REQ-010 SHALL increment dut_sram_read_address by 1 on each clock with incr_raddr_enable=1, wrapping 12'hFFF to 12'h000.
REQ-011 SHALL increment dut_sram_write_address by 1 on each clock with incr_waddr_enable=1, wrapping modulo 4096.
REQ-012 SHALL set dut_wmem_read_address to 12'h000 on rst_dut_wmem_read_address.
REQ-013 SHALL set dut_wmem_read_address to 12'h001 on str_weights_dims, after which the weight data word is at address 1.
REQ-014 SHALL give rst_dut_wmem_read_address priority over str_weights_dims when both are asserted.
REQ-015 SHALL, on str_input_nrows, capture sram_dut_read_data[7:0] into nrows.
REQ-016 SHALL, on str_input_nrows with data==16'h00FF, set end_condition_met=1 on the next edge and leave nrows unchanged.
REQ-017 SHALL, on str_input_ncols, capture sram_dut_read_data[7:0] into ncols.
REQ-018 SHALL clear col_cnt to 0 on rst_col_counter and otherwise add 1 on incr_col_enable.
REQ-019 SHALL clear row_cnt to 0 on rst_row_counter and otherwise add 1 on incr_row_enable.
REQ-020 SHALL give reset priority over increment in the same cycle for both counters.
REQ-021 SHALL hold col_cnt and row_cnt at 8'hFF when incremented at that value; they SHALL NOT wrap.
REQ-022 SHALL drive last_col_next combinationally as 1 when ncols<3 or col_cnt>=ncols-3.
REQ-023 SHALL drive last_row_flag combinationally as 1 when nrows<3 or row_cnt>=nrows-3.
REQ-024 SHALL compute all comparisons in 9-bit unsigned arithmetic so no underflow occurs.
REQ-025 SHALL act on strobes regardless of FSM state, so header reads before BUSY behave identically.
REQ-026 SHALL hold every register when no strobe is asserted.

Reset
REQ-027 SHALL, on reset_b=0 at any time, including mid-run, immediately force:
- FSM to IDLE.
- All three addresses to 12'h000.
- nrows, ncols, col_cnt and row_cnt to 0.
- dut_busy and end_condition_met to 0.
REQ-028 SHALL drive last_col_next=1 and last_row_flag=1 during reset because the dimensions are 0.
REQ-029 SHALL resume normal operation on the first rising edge after reset_b returns to 1.

Verification
REQ-030 Header: dut_busy_toggle, then str_input_nrows with data 16'h0008, then str_input_ncols with data 16'h000A -> dut_busy=1, nrows=8, ncols=10, last_col_next=0, last_row_flag=0.
REQ-031 Column sweep, ncols=10: 7 incr_col_enable pulses -> last_col_next rises after the 7th pulse (col_cnt=7); rst_col_counter together with incr_col_enable -> col_cnt=0.
REQ-032 Sentinel: str_input_nrows with data 16'h00FF while BUSY -> end_condition_met=1 and dut_busy=0 one cycle later; nrows keeps its prior value.
REQ-033 Wrap: read address at 12'hFFF plus one incr_raddr_enable -> 12'h000; 3 incr_waddr_enable pulses followed by a new dut_busy_toggle from IDLE -> write address 0.
REQ-034 Weights: str_weights_dims -> wmem address 1; rst_dut_wmem_read_address together with str_weights_dims -> wmem address 0.
REQ-035 Reset mid-run: reset_b=0 while BUSY with counters nonzero -> all outputs take their reset values immediately, without waiting for a clock edge.
